// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus bridge (mem_bus_ctrl).
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DATA} state_e;

  localparam int BASE_W = 16;
  localparam int LEN_W  = 16;
  localparam int WS_W   = 4;

  localparam logic [15:0] VACANT_WORD = 16'h3FFF;
  localparam logic [15:0] VACANT_BYTE = 16'h00FF;

  // Zero-extended byte lane for byte reads, full word otherwise.
  function automatic logic [15:0] read_lane(input logic [15:0] d, input logic bw, input logic hi);
    return !bw ? d : (hi ? {8'h00, d[15:8]} : {8'h00, d[7:0]});
  endfunction

  // Byte write enables {hi,lo} for one region.
  function automatic logic [1:0] write_lanes(input logic bw, input logic hi);
    return !bw ? 2'b11 : (hi ? 2'b10 : 2'b01);
  endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational region decoder: byte address -> hit, region index, wait states, read-only, word offset.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int                       NREG     = 4,
  parameter int                       AW       = 15,
  parameter int                       IDXW     = 2,
  parameter logic [BASE_W*NREG-1:0]   REG_BASE = '0,
  parameter logic [LEN_W*NREG-1:0]    REG_LEN  = '0,
  parameter logic [WS_W*NREG-1:0]     REG_WS   = '0,
  parameter logic [NREG-1:0]          REG_RO   = '0
) (
  input  logic [15:0]     addr,
  output logic            hit,
  output logic [IDXW-1:0] idx,
  output logic [WS_W-1:0] ws,
  output logic            ro,
  output logic [AW-1:0]   word_off
);

  logic [16:0] base;
  logic [16:0] lim;
  logic [15:0] diff;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    ws       = '0;
    ro       = 1'b0;
    word_off = '0;
    base     = '0;
    lim      = '0;
    diff     = '0;
    // Descending scan so the lowest matching index is the one left standing; 17-bit end allows 0x10000.
    for (int i = NREG - 1; i >= 0; i--) begin
      base = {1'b0, REG_BASE[BASE_W*i +: BASE_W]};
      lim  = base + {1'b0, REG_LEN[LEN_W*i +: LEN_W]};
      if (({1'b0, addr} >= base) && ({1'b0, addr} < lim)) begin
        hit      = 1'b1;
        idx      = IDXW'(i);
        ws       = REG_WS[WS_W*i +: WS_W];
        ro       = REG_RO[i];
        diff     = addr - REG_BASE[BASE_W*i +: BASE_W];
        word_off = AW'(diff >> 1);
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Registered CPU bus (MAB/MDB) to NREG block-memory bridge with wait states and violation flags.
// Optional MEMBUS_VIOL_CAPTURE_EN adds VIOL_CLR/VIOL_VALID/VIOL_ADDR first-violation capture.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                     NREG     = 4,
  parameter int                     AW       = 15,
  parameter logic [BASE_W*NREG-1:0] REG_BASE = {16'hFF80, 16'h4400, 16'h1C00, 16'h1000},
  parameter logic [LEN_W*NREG-1:0]  REG_LEN  = {16'h0080, 16'hBB80, 16'h0800, 16'h0800},
  parameter logic [WS_W*NREG-1:0]   REG_WS   = {4'd1, 4'd1, 4'd0, 4'd0},
  parameter logic [NREG-1:0]        REG_RO   = 4'b0001
) (
  input  logic                 MCLK,
  input  logic                 RST,
  input  logic                 MREQ,
  input  logic [15:0]          MAB,
  input  logic [15:0]          MDBwrite,
  input  logic                 MW,
  input  logic                 BW,
  output logic [15:0]          MDBread,
  output logic                 MRDY,
  output logic                 VMAIFG,
  output logic                 ACCVIFG,
  output logic [NREG-1:0]      mem_en,
  output logic [2*NREG-1:0]    mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [15:0]          mem_din,
  input  logic [16*NREG-1:0]   mem_dout
`ifdef MEMBUS_VIOL_CAPTURE_EN
  ,
  input  logic                 VIOL_CLR,
  output logic                 VIOL_VALID,
  output logic [15:0]          VIOL_ADDR
`endif
);

  localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e            state_q, state_d;
  logic              dec_hit, dec_ro;
  logic [IDXW-1:0]   dec_idx;
  logic [WS_W-1:0]   dec_ws;
  logic [AW-1:0]     dec_word_off;

  logic              hit_q, hit_d, ro_q, ro_d, mw_q, mw_d, bw_q, bw_d, hi_q, hi_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic [15:0]       mdbread_q, mdbread_d, din_q, din_d;
  logic              mrdy_q, mrdy_d, vmaifg_q, vmaifg_d, accvifg_q, accvifg_d;
  logic [NREG-1:0]   en_q, en_d;
  logic [2*NREG-1:0] we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;

  mem_bus_decode #(
    .NREG(NREG), .AW(AW), .IDXW(IDXW),
    .REG_BASE(REG_BASE), .REG_LEN(REG_LEN), .REG_WS(REG_WS), .REG_RO(REG_RO)
  ) u_decode (
    .addr(MAB), .hit(dec_hit), .idx(dec_idx), .ws(dec_ws), .ro(dec_ro), .word_off(dec_word_off)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (MREQ) state_d = ACCESS;
      ACCESS, WAIT: state_d = (cnt_q == '0) ? DATA : WAIT;
      DATA:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_d = hit_q; ro_d = ro_q; mw_d = mw_q; bw_d = bw_q; hi_d = hi_q; idx_d = idx_q; cnt_d = cnt_q;
    mdbread_d = mdbread_q; mrdy_d = mrdy_q; vmaifg_d = 1'b0; accvifg_d = 1'b0;
    en_d = en_q; we_d = we_q; addr_d = addr_q; din_d = din_q;
    case (state_q)
      IDLE: if (MREQ) begin
        hit_d  = dec_hit; ro_d = dec_ro; mw_d = MW; bw_d = BW; hi_d = MAB[0];
        idx_d  = dec_idx; cnt_d = dec_ws; mrdy_d = 1'b0; addr_d = dec_word_off;
        din_d  = !BW ? MDBwrite : (MAB[0] ? {MDBwrite[7:0], 8'h00} : {8'h00, MDBwrite[7:0]});
        en_d   = '0;
        we_d   = '0;
        // Vacant accesses and writes to read-only regions never touch the memories.
        if (dec_hit && !(MW && dec_ro)) begin
          en_d = NREG'(1) << dec_idx;
          if (MW) we_d = (2*NREG)'(write_lanes(BW, MAB[0])) << {dec_idx, 1'b0};
        end
      end
      ACCESS, WAIT: begin
        we_d = '0;
        if (cnt_q == '0) en_d  = '0;
        else             cnt_d = cnt_q - WS_W'(1);
      end
      DATA: begin
        mrdy_d = 1'b1;
        if (!hit_q) begin
          vmaifg_d = 1'b1;
          if (!mw_q) mdbread_d = bw_q ? VACANT_BYTE : VACANT_WORD;
        end else if (mw_q) begin
          accvifg_d = ro_q;
        end else begin
          mdbread_d = read_lane(mem_dout[16*idx_q +: 16], bw_q, hi_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) begin
      hit_q <= 1'b0; ro_q <= 1'b0; mw_q <= 1'b0; bw_q <= 1'b0; hi_q <= 1'b0;
      idx_q <= '0; cnt_q <= '0; mdbread_q <= '0; mrdy_q <= 1'b1;
      vmaifg_q <= 1'b0; accvifg_q <= 1'b0;
      en_q <= '0; we_q <= '0; addr_q <= '0; din_q <= '0;
    end else begin
      hit_q <= hit_d; ro_q <= ro_d; mw_q <= mw_d; bw_q <= bw_d; hi_q <= hi_d;
      idx_q <= idx_d; cnt_q <= cnt_d; mdbread_q <= mdbread_d; mrdy_q <= mrdy_d;
      vmaifg_q <= vmaifg_d; accvifg_q <= accvifg_d;
      en_q <= en_d; we_q <= we_d; addr_q <= addr_d; din_q <= din_d;
    end
  end

  assign MDBread  = mdbread_q;
  assign MRDY     = mrdy_q;
  assign VMAIFG   = vmaifg_q;
  assign ACCVIFG  = accvifg_q;
  assign mem_en   = en_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

`ifdef MEMBUS_VIOL_CAPTURE_EN
  logic [15:0] mab_q, mab_d, viol_addr_q, viol_addr_d;
  logic        viol_valid_q, viol_valid_d, viol_event;

  assign viol_event = (state_q == DATA) && (!hit_q || (mw_q && ro_q));

  // A coinciding clear and event leaves the new event captured.
  always_comb begin
    mab_d        = mab_q;
    viol_valid_d = viol_valid_q;
    viol_addr_d  = viol_addr_q;
    if (state_q == IDLE && MREQ) mab_d = MAB;
    if (viol_event && (!viol_valid_q || VIOL_CLR)) begin
      viol_valid_d = 1'b1;
      viol_addr_d  = mab_q;
    end else if (VIOL_CLR) begin
      viol_valid_d = 1'b0;
      viol_addr_d  = '0;
    end
  end

  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) begin
      mab_q <= '0; viol_valid_q <= 1'b0; viol_addr_q <= '0;
    end else begin
      mab_q <= mab_d; viol_valid_q <= viol_valid_d; viol_addr_q <= viol_addr_d;
    end
  end

  assign VIOL_VALID = viol_valid_q;
  assign VIOL_ADDR  = viol_addr_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with a behavioural model of the four block memories.
module tb_mem_bus_ctrl;

  localparam int NREG = 4;
  localparam int AW   = 15;

  logic              MCLK = 1'b0;
  logic              RST = 1'b0;
  logic              MREQ = 1'b0;
  logic [15:0]       MAB = '0;
  logic [15:0]       MDBwrite = '0;
  logic              MW = 1'b0;
  logic              BW = 1'b0;
  logic [15:0]       MDBread;
  logic              MRDY, VMAIFG, ACCVIFG;
  logic [NREG-1:0]   mem_en;
  logic [2*NREG-1:0] mem_we;
  logic [AW-1:0]     mem_addr;
  logic [15:0]       mem_din;
  logic [16*NREG-1:0] mem_dout;
`ifdef MEMBUS_VIOL_CAPTURE_EN
  logic              VIOL_CLR = 1'b0;
  logic              VIOL_VALID;
  logic [15:0]       VIOL_ADDR;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 MCLK = ~MCLK;

  mem_bus_ctrl dut (
    .MCLK(MCLK), .RST(RST), .MREQ(MREQ), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
    .MDBread(MDBread), .MRDY(MRDY), .VMAIFG(VMAIFG), .ACCVIFG(ACCVIFG),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEMBUS_VIOL_CAPTURE_EN
    , .VIOL_CLR(VIOL_CLR), .VIOL_VALID(VIOL_VALID), .VIOL_ADDR(VIOL_ADDR)
`endif
  );

  // Regions 0 (BSL) and 3 (IVT) behave as ROMs returning base pattern + word address.
  logic [15:0] mem_arr [NREG][32768];
  logic [15:0] rd_q [NREG];
  assign mem_dout = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

  always @(posedge MCLK) begin
    for (int r = 0; r < NREG; r++) begin
      if (mem_en[r]) begin
        if (r == 0 || r == 3) begin
          rd_q[r] <= ((r == 0) ? 16'h0B00 : 16'hC000) + {1'b0, mem_addr};
        end else begin
          rd_q[r] <= mem_arr[r][mem_addr];
          if (mem_we[2*r])   mem_arr[r][mem_addr][7:0]  <= mem_din[7:0];
          if (mem_we[2*r+1]) mem_arr[r][mem_addr][15:8] <= mem_din[15:8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // Issue a request, then scramble the bus while MREQ stays held to prove operands are latched.
  task automatic start(input logic [15:0] a, input logic [15:0] d, input logic w, input logic b);
    MAB = a; MDBwrite = d; MW = w; BW = b; MREQ = 1'b1;
    tick();
    MAB = ~a; MDBwrite = ~d; MW = ~w; BW = ~b;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (MRDY !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    MREQ = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) tick();
    check("rst_mrdy", MRDY, 1);
    check("rst_mdbread", MDBread, 0);
    check("rst_flags", {VMAIFG, ACCVIFG}, 0);
    check("rst_en_we", {mem_en, mem_we}, 0);
    check("rst_addr_din", {mem_addr, mem_din}, 0);
    RST = 1'b1;

    // RAM word write
    start(16'h1C02, 16'hBEEF, 1'b1, 1'b0);
    check("ramw_en", mem_en, 4'b0010);
    check("ramw_we", mem_we, 8'b0000_1100);
    check("ramw_addr", mem_addr, 1);
    check("ramw_din", mem_din, 16'hBEEF);
    wait_rdy(n);
    check("ramw_lat", n, 2);
    check("ramw_flags", {VMAIFG, ACCVIFG}, 0);

    // Byte lanes
    start(16'h1C03, 16'h00A5, 1'b1, 1'b1);
    check("bw_hi_we", mem_we, 8'b0000_1000);
    check("bw_hi_din", mem_din, 16'hA500);
    check("bw_hi_addr", mem_addr, 1);
    wait_rdy(n);
    start(16'h1C04, 16'h005A, 1'b1, 1'b1);
    check("bw_lo_we", mem_we, 8'b0000_0100);
    check("bw_lo_din", mem_din, 16'h005A);
    wait_rdy(n);
    start(16'h1C02, 16'h0000, 1'b0, 1'b0);
    check("ramr_we", mem_we, 0);
    wait_rdy(n);
    check("ramr_lat", n, 2);
    check("ramr_data", MDBread, 16'hA5EF);
    start(16'h1C03, 16'h0000, 1'b0, 1'b1);
    wait_rdy(n);
    check("br_hi", MDBread, 16'h00A5);
    start(16'h1C02, 16'h0000, 1'b0, 1'b1);
    wait_rdy(n);
    check("br_lo", MDBread, 16'h00EF);

    // FRAM: write enable only in first cycle, enable held through the wait state
    start(16'h4400, 16'h1234, 1'b1, 1'b0);
    check("fw_we0", mem_we, 8'b0011_0000);
    check("fw_en0", mem_en, 4'b0100);
    tick();
    check("fw_we1", mem_we, 0);
    check("fw_en1", mem_en, 4'b0100);
    wait_rdy(n);
    check("fw_lat", n + 1, 3);
    start(16'h4400, 16'h0000, 1'b0, 1'b0);
    check("fr_en0", mem_en, 4'b0100);
    check("fr_addr", mem_addr, 0);
    tick();
    check("fr_en1", {mem_en, MRDY}, {4'b0100, 1'b0});
    wait_rdy(n);
    check("fr_lat", n + 1, 3);
    check("fr_en_off", mem_en, 0);
    check("fr_data", MDBread, 16'h1234);

    // IVT at the top of the address space (region end 0x10000)
    start(16'hFFFE, 16'h0000, 1'b0, 1'b0);
    check("ivt_en", mem_en, 4'b1000);
    check("ivt_addr", mem_addr, 15'h3F);
    wait_rdy(n);
    check("ivt_lat", n, 3);
    check("ivt_data", MDBread, 16'hC03F);

    // Read-only region read works normally
    start(16'h1000, 16'h0000, 1'b0, 1'b0);
    check("ror_en", mem_en, 4'b0001);
    wait_rdy(n);
    check("ror_data", MDBread, 16'h0B00);
    check("ror_flags", {VMAIFG, ACCVIFG}, 0);

    // Vacant accesses
    start(16'h0800, 16'h0000, 1'b0, 1'b0);
    check("vac_en", mem_en, 0);
    wait_rdy(n);
    check("vac_lat", n, 2);
    check("vac_data", MDBread, 16'h3FFF);
    check("vac_pulse", {VMAIFG, ACCVIFG}, 2'b10);
    tick();
    check("vac_pulse_end", VMAIFG, 0);
`ifdef MEMBUS_VIOL_CAPTURE_EN
    check("viol_vac", {VIOL_VALID, VIOL_ADDR}, {1'b1, 16'h0800});
`endif
    start(16'h0801, 16'h0000, 1'b0, 1'b1);
    wait_rdy(n);
    check("vac_byte", MDBread, 16'h00FF);
    check("vac_byte_pulse", VMAIFG, 1);
`ifdef MEMBUS_VIOL_CAPTURE_EN
    check("viol_keep", VIOL_ADDR, 16'h0800);
    VIOL_CLR = 1'b1;
    tick();
    VIOL_CLR = 1'b0;
    check("viol_clr", {VIOL_VALID, VIOL_ADDR}, 0);
`endif

    // Write to read-only region is suppressed
    start(16'h1000, 16'hDEAD, 1'b1, 1'b0);
    check("ro_en_we", {mem_en, mem_we}, 0);
    wait_rdy(n);
    check("ro_pulse", {VMAIFG, ACCVIFG}, 2'b01);
    check("ro_keep", MDBread, 16'h00FF);
    tick();
    check("ro_pulse_end", ACCVIFG, 0);
`ifdef MEMBUS_VIOL_CAPTURE_EN
    check("viol_ro", {VIOL_VALID, VIOL_ADDR}, {1'b1, 16'h1000});
`endif

    // Reset during the FRAM wait cycle
    start(16'h4402, 16'h0000, 1'b0, 1'b0);
    tick();
    check("rstw_en", mem_en, 4'b0100);
    RST = 1'b0;
    #1;
    check("rstw_en_off", mem_en, 0);
    check("rstw_mrdy", MRDY, 1);
    check("rstw_mdbread", MDBread, 0);
    MREQ = 1'b0;
    tick();
    RST = 1'b1;
    start(16'h1C02, 16'h0000, 1'b0, 1'b0);
    wait_rdy(n);
    check("post_rst_lat", n, 2);
    check("post_rst_data", MDBread, 16'hA5EF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
